// File: rtl/apmu_ibex_pkg.sv
// Shared types for the PMU memory arbiter: requester id type and the requester-count limit.
package apmu_ibex_pkg;

    localparam int unsigned ARB_MAX_REQ = 8;

    typedef logic [$clog2(ARB_MAX_REQ)-1:0] arb_id_t;

    function automatic arb_id_t arb_next_id(arb_id_t id, int unsigned num_req);
        return (32'(id) + 32'd1 >= num_req) ? arb_id_t'(0) : arb_id_t'(32'(id) + 32'd1);
    endfunction

endpackage

// File: rtl/ibex_pmu_arb_id_fifo.sv
// In-order FIFO of requester ids, one entry per granted-but-unanswered memory transaction.
// Latency: head is valid the cycle after push; same-cycle push+pop keeps the count.
// Backpressure: push ignored when full, pop ignored when empty; the owner gates both.
module ibex_pmu_arb_id_fifo
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  arb_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output arb_id_t head
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    arb_id_t         mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] wrap_inc(logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wrap_inc(wptr);
            if (do_pop)  rptr <= wrap_inc(rptr);
            if (do_push && !do_pop)      count <= count + CntW'(1);
            else if (do_pop && !do_push) count <= count - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_id;
    end

endmodule

// File: rtl/ibex_pmu_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between NumReq requesters; optional counters via APMU_ARB_PERF_EN.
// Latency: request and response paths are combinational (0 cycles).
// Backpressure: winner held until mem_gnt_i; new requests blocked while MaxOutstanding responses are pending.
module ibex_pmu_mem_arbiter
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic [NumReq-1:0]       rvalid_o,
    output logic [NumReq-1:0]       err_o,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq-1:0]       we_i,
    input  logic [NumReq*4-1:0]     be_i,
    input  logic [NumReq*32-1:0]    wdata_i,
    output logic [31:0]             rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [AddrWidth-1:0]    mem_addr_o,
    output logic                    mem_we_o,
    output logic [3:0]              mem_be_o,
    output logic [31:0]             mem_wdata_o,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_err_i,
    output logic                    unexp_rsp_o,
    output logic [NumReq*32-1:0]    perf_gnt_cnt_o,
    output logic [NumReq*32-1:0]    perf_stall_o
);

    logic    lock_q;
    arb_id_t lock_id_q;
    arb_id_t rr_ptr_q;
    arb_id_t winner;
    arb_id_t first_any;
    arb_id_t first_hi;
    logic    hi_found;
    logic    locked_req;
    logic    mem_req;
    logic    handshake;
    logic    pop;
    logic    fifo_full;
    logic    fifo_empty;
    arb_id_t head;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        first_any = '0;
        first_hi  = '0;
        hi_found  = 1'b0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                first_any = arb_id_t'(i);
                if (i >= int'(rr_ptr_q)) begin
                    first_hi = arb_id_t'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign winner    = lock_q ? lock_id_q : (hi_found ? first_hi : first_any);
    assign mem_req   = ~rst_i & (lock_q ? locked_req : (|req_i & ~fifo_full));
    assign handshake = mem_req & mem_gnt_i;
    assign pop       = ~rst_i & mem_rvalid_i & ~fifo_empty;
    assign mem_req_o = mem_req;
    assign rdata_o   = rst_i ? '0 : mem_rdata_i;

    always_comb begin
        locked_req  = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        err_o       = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (arb_id_t'(i) == lock_id_q) locked_req = req_i[i];
            if (arb_id_t'(i) == winner && !rst_i) begin
                mem_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                mem_we_o    = we_i[i];
                mem_be_o    = be_i[i*4 +: 4];
                mem_wdata_o = wdata_i[i*32 +: 32];
            end
            gnt_o[i]    = handshake & (arb_id_t'(i) == winner);
            rvalid_o[i] = pop & (arb_id_t'(i) == head);
            err_o[i]    = pop & mem_err_i & (arb_id_t'(i) == head);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            unexp_rsp_o <= 1'b0;
        end else begin
            if (handshake) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= arb_next_id(winner, NumReq);
            end else if (mem_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= winner;
            end else begin
                lock_q <= 1'b0;
            end
            if (mem_rvalid_i && fifo_empty) unexp_rsp_o <= 1'b1;
        end
    end

    ibex_pmu_arb_id_fifo #(
        .Depth(MaxOutstanding)
    ) u_id_fifo (
        .clk    (clk_i),
        .rst    (rst_i),
        .push   (handshake),
        .push_id(winner),
        .pop    (pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

`ifdef APMU_ARB_PERF_EN
    logic [31:0] gnt_cnt_q   [NumReq];
    logic [31:0] stall_cnt_q [NumReq];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NumReq); i++) begin
            if (rst_i) begin
                gnt_cnt_q[i]   <= '0;
                stall_cnt_q[i] <= '0;
            end else begin
                if (gnt_o[i] && gnt_cnt_q[i] != '1) gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
                if (req_i[i] && !gnt_o[i] && stall_cnt_q[i] != '1)
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(NumReq); g++) begin : g_perf
        assign perf_gnt_cnt_o[g*32 +: 32] = gnt_cnt_q[g];
        assign perf_stall_o[g*32 +: 32]   = stall_cnt_q[g];
    end
`else
    assign perf_gnt_cnt_o = '0;
    assign perf_stall_o   = '0;
`endif

endmodule

// File: tb/tb_ibex_pmu_mem_arbiter.sv
// Self-checking bench for ibex_pmu_mem_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_ibex_pmu_mem_arbiter;

    localparam int N  = 2;
    localparam int MO = 2;
    localparam int AW = 32;
`ifdef APMU_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req, gnt, rvalid, err, we;
    logic [N*AW-1:0]   addr;
    logic [N*4-1:0]    be;
    logic [N*32-1:0]   wdata;
    logic [31:0]       rdata;
    logic              mem_req, mem_gnt, mem_rvalid, mem_we, mem_err, unexp;
    logic [AW-1:0]     mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [N*32-1:0]   perf_gnt, perf_stall;

    ibex_pmu_mem_arbiter #(.NumReq(N), .MaxOutstanding(MO), .AddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid), .err_o(err),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .unexp_rsp_o(unexp),
        .perf_gnt_cnt_o(perf_gnt), .perf_stall_o(perf_stall)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: round-robin start, held winner, queue of outstanding ids.
    int m_rr;
    bit m_lock;
    int m_lock_id;
    int m_q[$];
    bit m_unexp;
    int m_gcnt[N];
    int m_scnt[N];

    int           e_win;
    bit           e_req;
    logic [N-1:0] e_gnt, e_rvalid, e_err;

    task automatic model_comb();
        bit found;
        found = 1'b0;
        e_win = 0;
        if (m_lock) e_win = m_lock_id;
        else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (!found && req[i]) begin
                    e_win = i;
                    found = 1'b1;
                end
            end
        end
        if (rst)         e_req = 1'b0;
        else if (m_lock) e_req = req[m_lock_id];
        else             e_req = (|req) && (m_q.size() < MO);
        e_gnt = '0;
        if (e_req && mem_gnt) e_gnt[e_win] = 1'b1;
        e_rvalid = '0;
        e_err    = '0;
        if (!rst && mem_rvalid && m_q.size() > 0) begin
            e_rvalid[m_q[0]] = 1'b1;
            e_err[m_q[0]]    = mem_err;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_rr = 0; m_lock = 0; m_lock_id = 0; m_unexp = 0;
            m_q.delete();
            for (int i = 0; i < N; i++) begin m_gcnt[i] = 0; m_scnt[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i]) m_gcnt[i]++;
                if (req[i] && !e_gnt[i]) m_scnt[i]++;
            end
            if (mem_rvalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_unexp = 1'b1;
            end
            if (e_req && mem_gnt) begin
                m_q.push_back(e_win);
                m_rr = (e_win + 1) % N;
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock = 1'b1;
                m_lock_id = e_win;
            end else begin
                m_lock = 1'b0;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (mem_req !== 1'b0 || gnt !== 2'b00 || rvalid !== 2'b00 || err !== 2'b00) begin
                failures++;
                $display("FAIL reset_outputs: got req=%b gnt=%b rvalid=%b err=%b, expected all 0",
                         mem_req, gnt, rvalid, err);
            end
            checks++;
            if (rdata !== 32'h0 || mem_addr !== '0) begin
                failures++;
                $display("FAIL reset_data: got rdata=%h addr=%h, expected 0", rdata, mem_addr);
            end
            tick();
        end
        checks++;
        if (unexp !== 1'b0 || perf_gnt !== '0 || perf_stall !== '0) begin
            failures++;
            $display("FAIL reset_state: got unexp=%b gnt_cnt=%h stall=%h, expected 0",
                     unexp, perf_gnt, perf_stall);
        end
        idle_inputs();
        settle();
        tick();
    endtask

    // Both requesters held, memory always grants and answers one cycle later.
    task automatic test_round_robin();
        logic [N-1:0] prev;
        logic [N-1:0] want;
        prev = '0;
        req = 2'b11; mem_gnt = 1'b1; we = 2'b00;
        for (int k = 0; k < 6; k++) begin
            mem_rvalid = (k > 0);
            settle();
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== want) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, gnt, want);
            end
            checks++;
            if (rvalid !== prev) begin
                failures++;
                $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, prev);
            end
            prev = want;
            tick();
        end
        req = '0; mem_rvalid = 1'b1;
        settle();
        checks++;
        if (rvalid !== 2'b10) begin
            failures++;
            $display("FAIL rr_drain: got %b expected 10", rvalid);
        end
        tick();
        idle_inputs();
    endtask

    // Requester 1 waits without grant; requester 0 arriving later must not steal the port.
    task automatic test_lock();
        req = 2'b10; mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req = 2'b11;
            settle();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr[AW +: AW] || gnt !== 2'b00) begin
                failures++;
                $display("FAIL lock_hold[%0d]: got req=%b addr=%h gnt=%b expected 1 %h 00",
                         k, mem_req, mem_addr, addr[AW +: AW], gnt);
            end
            tick();
        end
        mem_gnt = 1'b1;
        settle();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL lock_first_grant: got %b expected 10", gnt);
        end
        tick();
        settle();
        checks++;
        if (gnt !== 2'b01 || mem_addr !== addr[0 +: AW]) begin
            failures++;
            $display("FAIL lock_second_grant: got gnt=%b addr=%h expected 01 %h", gnt, mem_addr, addr[0 +: AW]);
        end
        tick();
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if (rvalid !== ((k == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL lock_rsp[%0d]: got %b", k, rvalid);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        logic [N-1:0] want_gnt [5];
        logic         want_req [5];
        want_gnt = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        want_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        req = 2'b01; mem_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = (k == 3);
            settle();
            checks++;
            if (gnt !== want_gnt[k] || mem_req !== want_req[k]) begin
                failures++;
                $display("FAIL full[%0d]: got gnt=%b req=%b expected %b %b",
                         k, gnt, mem_req, want_gnt[k], want_req[k]);
            end
            if (k == 3) begin
                checks++;
                if (rvalid !== 2'b01) begin
                    failures++;
                    $display("FAIL full_pop: got rvalid=%b expected 01", rvalid);
                end
            end
            tick();
        end
        req = '0; mem_rvalid = 1'b1;
        settle(); tick();
        settle(); tick();
        idle_inputs();
    endtask

    task automatic test_err();
        logic [31:0] rd;
        rd = $urandom;
        req = 2'b10; we = 2'b00; mem_gnt = 1'b1;
        settle();
        checks++;
        if (gnt !== 2'b10 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL err_grant: got gnt=%b we=%b expected 10 0", gnt, mem_we);
        end
        tick();
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = rd;
        settle();
        checks++;
        if (err !== 2'b10 || rvalid !== 2'b10 || rdata !== rd) begin
            failures++;
            $display("FAIL err_rsp: got err=%b rvalid=%b rdata=%h expected 10 10 %h", err, rvalid, rdata, rd);
        end
        tick();
        mem_rvalid = 1'b0;
        settle();
        checks++;
        if (err !== 2'b00) begin
            failures++;
            $display("FAIL err_clear: got %b expected 00", err);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_unexpected();
        mem_rvalid = 1'b1;
        settle();
        checks++;
        if (rvalid !== 2'b00 || unexp !== 1'b0) begin
            failures++;
            $display("FAIL unexp_before: got rvalid=%b unexp=%b expected 00 0", rvalid, unexp);
        end
        tick();
        mem_rvalid = 1'b0;
        settle();
        checks++;
        if (unexp !== 1'b1) begin
            failures++;
            $display("FAIL unexp_set: got %b expected 1", unexp);
        end
        tick();
        rst = 1'b1; settle(); tick();
        rst = 1'b0;
        req = 2'b01; mem_gnt = 1'b1;
        settle();
        checks++;
        if (unexp !== 1'b0 || gnt !== 2'b01) begin
            failures++;
            $display("FAIL unexp_cleared: got unexp=%b gnt=%b expected 0 01", unexp, gnt);
        end
        tick();
        req = '0; mem_gnt = 1'b0; rst = 1'b1; settle(); tick();
        rst = 1'b0; mem_rvalid = 1'b1;
        settle();
        checks++;
        if (rvalid !== 2'b00) begin
            failures++;
            $display("FAIL unexp_after_reset_rvalid: got %b expected 00", rvalid);
        end
        tick();
        mem_rvalid = 1'b0;
        settle();
        checks++;
        if (unexp !== 1'b1) begin
            failures++;
            $display("FAIL unexp_after_reset: got %b expected 1", unexp);
        end
        tick();
    endtask

    task automatic test_perf();
        rst = 1'b1; settle(); tick();
        idle_inputs();
        req = 2'b01;
        for (int k = 0; k < 6; k++) begin
            mem_gnt = (k == 5);
            settle(); tick();
        end
        req = '0; mem_gnt = 1'b0;
        settle();
        checks++;
        if (perf_stall[31:0] !== (PERF ? 32'd5 : 32'd0) || perf_gnt[31:0] !== (PERF ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL perf_counts: got stall=%0d gnt=%0d expected %0d %0d",
                     perf_stall[31:0], perf_gnt[31:0], PERF ? 5 : 0, PERF ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            req        = N'($urandom);
            mem_gnt    = $urandom_range(0, 1) == 1;
            mem_rvalid = $urandom_range(0, 9) < 4;
            mem_err    = $urandom_range(0, 1) == 1;
            mem_rdata  = $urandom;
            we         = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW]   = $urandom;
                be[i*4 +: 4]       = 4'($urandom);
                wdata[i*32 +: 32]  = $urandom;
            end
            settle();
            checks++;
            if (mem_req !== e_req || gnt !== e_gnt) begin
                failures++;
                $display("FAIL rnd_req[%0d]: got req=%b gnt=%b expected %b %b", c, mem_req, gnt, e_req, e_gnt);
            end
            checks++;
            if (rvalid !== e_rvalid || err !== e_err) begin
                failures++;
                $display("FAIL rnd_rsp[%0d]: got rvalid=%b err=%b expected %b %b", c, rvalid, err, e_rvalid, e_err);
            end
            checks++;
            if (rdata !== (rst ? 32'h0 : mem_rdata)) begin
                failures++;
                $display("FAIL rnd_rdata[%0d]: got %h", c, rdata);
            end
            if (e_req) begin
                checks++;
                if (mem_addr !== addr[e_win*AW +: AW] || mem_we !== we[e_win] ||
                    mem_be !== be[e_win*4 +: 4] || mem_wdata !== wdata[e_win*32 +: 32]) begin
                    failures++;
                    $display("FAIL rnd_mux[%0d]: got addr=%h we=%b be=%h wdata=%h for requester %0d",
                             c, mem_addr, mem_we, mem_be, mem_wdata, e_win);
                end
            end
            tick();
            checks++;
            if (unexp !== m_unexp) begin
                failures++;
                $display("FAIL rnd_unexp[%0d]: got %b expected %b", c, unexp, m_unexp);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (perf_gnt[i*32 +: 32] !== (PERF ? 32'(m_gcnt[i]) : 32'd0) ||
                    perf_stall[i*32 +: 32] !== (PERF ? 32'(m_scnt[i]) : 32'd0)) begin
                    failures++;
                    $display("FAIL rnd_perf[%0d][%0d]: got gnt=%0d stall=%0d expected %0d %0d", c, i,
                             perf_gnt[i*32 +: 32], perf_stall[i*32 +: 32], m_gcnt[i], m_scnt[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        we = '0; be = 8'hF3; mem_rdata = 32'h0;
        addr  = {32'hB000_0010, 32'hA000_0000};
        wdata = {32'h1111_2222, 32'h3333_4444};
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_err();
        test_unexpected();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
